attn_score_pingpong_buffer: RTL and testbench

Receiving end of the attention-score stream produced by the multi-head spikes-accumulation engine. Captures one full TOKENS×TOKENS score tile per head into a two-bank ping-pong RAM and drives the AttnRAM-ready flag that gates the producer's next head. Exposes completed tiles to the downstream softmax-free attention-times-V stage through a random-access read port with bank release handshake.

---
 rtl/attn_score_pingpong_buffer_pkg.sv | 27 ++
 rtl/attn_score_pingpong_buffer_if.sv | 27 ++
 rtl/attn_score_sdp_ram.sv | 26 ++
 rtl/attn_score_pingpong_buffer.sv | 122 ++++++++++++
 tb/tb_attn_score_pingpong_buffer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/attn_score_pingpong_buffer_pkg.sv
// Shared hyper-parameters and bank-state encoding for the attention-score ping-pong buffer.
package attn_score_pingpong_buffer_pkg;

   localparam int unsigned TIME_STEPS        = 4;
   localparam int unsigned SYSTOLIC_UNIT_NUM = 16;
   localparam int unsigned TOKENS            = 64;
   localparam int unsigned MULTI_HEAD_NUMS   = 12;

   localparam int unsigned LANE_W     = $clog2(2 * SYSTOLIC_UNIT_NUM);
   localparam int unsigned DATA_W     = LANE_W * TIME_STEPS;
   localparam int unsigned TILE_BEATS = TOKENS * TOKENS;
   localparam int unsigned ADDR_W     = $clog2(TILE_BEATS);
   localparam int unsigned HEAD_W     = 4;

   typedef enum logic [1:0] {
      BankFree    = 2'd0,
      BankFilling = 2'd1,
      BankFull    = 2'd2,
      BankReading = 2'd3
   } bank_state_e;

   // Head index advance with wrap at the last head of a layer.
   function automatic logic [HEAD_W-1:0] next_head(input logic [HEAD_W-1:0] head);
      return (head == HEAD_W'(MULTI_HEAD_NUMS - 1)) ? '0 : head + 1'b1;
   endfunction

endpackage

// File: rtl/attn_score_pingpong_buffer_if.sv
// Producer beat stream plus consumer read/release port of the score buffer.
interface attn_score_pingpong_buffer_if;
   import attn_score_pingpong_buffer_pkg::*;

   logic [DATA_W-1:0] i_Calc_data;
   logic              i_Calc_valid;
   logic              o_AttnRAM_Ready;
   logic              o_rd_bank_valid;
   logic [HEAD_W-1:0] o_rd_head_idx;
   logic              i_rd_en;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_rd_valid;
   logic              i_rd_done;
   logic              o_overflow;

   modport slave (
      input  i_Calc_data, i_Calc_valid, i_rd_en, i_rd_addr, i_rd_done,
      output o_AttnRAM_Ready, o_rd_bank_valid, o_rd_head_idx, o_rd_data, o_rd_valid, o_overflow
   );

   modport master (
      output i_Calc_data, i_Calc_valid, i_rd_en, i_rd_addr, i_rd_done,
      input  o_AttnRAM_Ready, o_rd_bank_valid, o_rd_head_idx, o_rd_data, o_rd_valid, o_overflow
   );

endinterface

// File: rtl/attn_score_sdp_ram.sv
// Simple dual-port RAM, one write and one registered read per cycle; no reset so it maps to BRAM.
module attn_score_sdp_ram
   import attn_score_pingpong_buffer_pkg::*;
#(
   parameter  int unsigned Depth = 2 * TILE_BEATS,
   parameter  int unsigned Width = DATA_W,
   localparam int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AddrW-1:0] wr_addr,
   input  logic [Width-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AddrW-1:0] rd_addr,
   output logic [Width-1:0] rd_data
);

   logic [Width-1:0] mem [Depth];

   // Write port and read register; read data holds when rd_en is low.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/attn_score_pingpong_buffer.sv
// Two-bank ping-pong capture of per-head score tiles with random-access read and bank release.
module attn_score_pingpong_buffer
   import attn_score_pingpong_buffer_pkg::*;
(
   input logic                         s_clk,
   input logic                         s_rst_n,
   attn_score_pingpong_buffer_if.slave bus
);

   bank_state_e [1:0]             bank_q, bank_d;
   logic        [1:0][HEAD_W-1:0] bank_head_q, bank_head_d;
   logic                          wr_bank_q, wr_bank_d;
   logic                          rd_bank_q, rd_bank_d;
   logic        [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic        [HEAD_W-1:0]      wr_head_q, wr_head_d;

   logic              ready_q, ready_d;
   logic              rd_bank_valid_q, rd_bank_valid_d;
   logic [HEAD_W-1:0] rd_head_q, rd_head_d;
   logic              overflow_q, overflow_d;
   logic              rd_valid_q;
   logic              rd_data_live_q;
   logic [DATA_W-1:0] ram_rd_data;

   logic wr_ok, wr_en, wr_last, rd_ok, rd_fire, rd_release;

   assign wr_ok      = bank_q[wr_bank_q] inside {BankFree, BankFilling};
   assign wr_en      = bus.i_Calc_valid & wr_ok;
   assign wr_last    = (wr_addr_q == ADDR_W'(TILE_BEATS - 1));
   assign rd_ok      = bank_q[rd_bank_q] inside {BankFull, BankReading};
   assign rd_fire    = bus.i_rd_en & rd_ok;
   assign rd_release = bus.i_rd_done & rd_ok;

   // Bank state machines and pointers; outputs are registered from next state so they
   // reflect a state change in the cycle right after it.
   always_comb begin
      bank_d      = bank_q;
      bank_head_d = bank_head_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_addr_d   = wr_addr_q;
      wr_head_d   = wr_head_q;
      // A write bank is never readable and vice versa, so the two updates never collide.
      if (wr_en) begin
         wr_addr_d = wr_addr_q + 1'b1;
         if (wr_last) begin
            bank_d[wr_bank_q]      = BankFull;
            bank_head_d[wr_bank_q] = wr_head_q;
            wr_bank_d              = ~wr_bank_q;
            wr_head_d              = next_head(wr_head_q);
         end else begin
            bank_d[wr_bank_q] = BankFilling;
         end
      end
      if (rd_release) begin
         bank_d[rd_bank_q] = BankFree;
         rd_bank_d         = ~rd_bank_q;
      end else if (rd_fire) begin
         bank_d[rd_bank_q] = BankReading;
      end
      ready_d         = bank_d[wr_bank_d] inside {BankFree, BankFilling};
      rd_bank_valid_d = bank_d[rd_bank_d] inside {BankFull, BankReading};
      rd_head_d       = bank_head_d[rd_bank_d];
      overflow_d      = overflow_q | (bus.i_Calc_valid & ~wr_ok);
   end

   // State and output registers.
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            bank_q[i]      <= BankFree;
            bank_head_q[i] <= '0;
         end
         wr_bank_q       <= 1'b0;
         rd_bank_q       <= 1'b0;
         wr_addr_q       <= '0;
         wr_head_q       <= '0;
         ready_q         <= 1'b1;
         rd_bank_valid_q <= 1'b0;
         rd_head_q       <= '0;
         overflow_q      <= 1'b0;
         rd_valid_q      <= 1'b0;
         rd_data_live_q  <= 1'b0;
      end else begin
         bank_q          <= bank_d;
         bank_head_q     <= bank_head_d;
         wr_bank_q       <= wr_bank_d;
         rd_bank_q       <= rd_bank_d;
         wr_addr_q       <= wr_addr_d;
         wr_head_q       <= wr_head_d;
         ready_q         <= ready_d;
         rd_bank_valid_q <= rd_bank_valid_d;
         rd_head_q       <= rd_head_d;
         overflow_q      <= overflow_d;
         rd_valid_q      <= rd_fire;
         rd_data_live_q  <= rd_data_live_q | rd_fire;
      end
   end

   attn_score_sdp_ram #(
      .Depth (2 * TILE_BEATS),
      .Width (DATA_W)
   ) u_ram (
      .clk     (s_clk),
      .wr_en   (wr_en),
      .wr_addr ({wr_bank_q, wr_addr_q}),
      .wr_data (bus.i_Calc_data),
      .rd_en   (rd_fire),
      .rd_addr ({rd_bank_q, bus.i_rd_addr}),
      .rd_data (ram_rd_data)
   );

   // The RAM read register has no reset; read data is forced to zero until the first read
   // after reset so stale contents never show.
   assign bus.o_rd_data       = ram_rd_data & {DATA_W{rd_data_live_q}};
   assign bus.o_rd_valid      = rd_valid_q;
   assign bus.o_AttnRAM_Ready = ready_q;
   assign bus.o_rd_bank_valid = rd_bank_valid_q;
   assign bus.o_rd_head_idx   = rd_head_q;
   assign bus.o_overflow      = overflow_q;

endmodule

// File: tb/tb_attn_score_pingpong_buffer.sv
// Randomized bench for the score ping-pong buffer against a tile-queue reference model.
module tb_attn_score_pingpong_buffer;
   import attn_score_pingpong_buffer_pkg::*;

   localparam int NumTiles = 64;

   logic s_clk = 1'b0;
   logic s_rst_n = 1'b0;
   always #5 s_clk = ~s_clk;

   attn_score_pingpong_buffer_if bus ();

   attn_score_pingpong_buffer dut (
      .s_clk   (s_clk),
      .s_rst_n (s_rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: completed tiles form a FIFO of at most two; beats are accepted only
   // while fewer than two completed tiles are held. Tile contents are salt + address.
   int                full_q[$];
   int                tile_head[NumTiles];
   logic [DATA_W-1:0] tile_salt[NumTiles];
   int                n_tiles = 0;
   int                tiles_since_reset;
   int                cur_tile;
   int                wr_cnt;
   bit                ovf;
   bit                exp_rd_valid;
   logic [DATA_W-1:0] exp_rd_data;

   function automatic logic [DATA_W-1:0] data_for(input int id, input int addr);
      return tile_salt[id] + DATA_W'(addr);
   endfunction

   function automatic int new_tile();
      int id;
      id = n_tiles;
      n_tiles++;
      tile_head[id] = tiles_since_reset % MULTI_HEAD_NUMS;
      tiles_since_reset++;
      tile_salt[id] = DATA_W'($urandom);
      return id;
   endfunction

   task automatic model_reset();
      full_q.delete();
      tiles_since_reset = 0;
      cur_tile          = new_tile();
      wr_cnt            = 0;
      ovf               = 1'b0;
      exp_rd_valid      = 1'b0;
      exp_rd_data       = '0;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_outputs();
      check_eq("ready", 32'(bus.o_AttnRAM_Ready), 32'(full_q.size() < 2));
      check_eq("rd_bank_valid", 32'(bus.o_rd_bank_valid), 32'(full_q.size() > 0));
      if (full_q.size() > 0) check_eq("rd_head_idx", 32'(bus.o_rd_head_idx), tile_head[full_q[0]]);
      check_eq("overflow", 32'(bus.o_overflow), 32'(ovf));
      check_eq("rd_valid", 32'(bus.o_rd_valid), 32'(exp_rd_valid));
      check_eq("rd_data", 32'(bus.o_rd_data), 32'(exp_rd_data));
   endtask

   task automatic drive_idle();
      bus.i_Calc_valid = 1'b0;
      bus.i_Calc_data  = '0;
      bus.i_rd_en      = 1'b0;
      bus.i_rd_addr    = '0;
      bus.i_rd_done    = 1'b0;
   endtask

   // One clock with the given inputs, then advance the model and compare.
   task automatic tick(input bit v, input logic [DATA_W-1:0] d, input bit re,
                       input logic [ADDR_W-1:0] ra, input bit dn);
      bit avail;
      bit wr_open;
      bus.i_Calc_valid = v;
      bus.i_Calc_data  = d;
      bus.i_rd_en      = re;
      bus.i_rd_addr    = ra;
      bus.i_rd_done    = dn;
      @(posedge s_clk);
      #1;
      avail   = full_q.size() > 0;
      wr_open = full_q.size() < 2;
      if (re && avail) begin
         exp_rd_valid = 1'b1;
         exp_rd_data  = data_for(full_q[0], int'(ra));
      end else begin
         exp_rd_valid = 1'b0;
      end
      if (v) begin
         if (!wr_open) begin
            ovf = 1'b1;
         end else begin
            wr_cnt++;
            if (wr_cnt == TILE_BEATS) begin
               full_q.push_back(cur_tile);
               cur_tile = new_tile();
               wr_cnt   = 0;
            end
         end
      end
      if (dn && avail) void'(full_q.pop_front());
      check_outputs();
   endtask

   // Stream one tile with random gaps and concurrent random reads of the readable tile.
   task automatic stream_tile(input int gap_pct, input bit release_at_last);
      int start;
      int budget;
      bit last;
      bit v;
      bit re;
      bit dn;
      logic [ADDR_W-1:0] ra;
      start  = cur_tile;
      budget = 0;
      while (cur_tile == start && budget < 3 * TILE_BEATS) begin
         last = (wr_cnt == TILE_BEATS - 1);
         v    = (last && release_at_last) || ($urandom_range(99) >= gap_pct);
         re   = 1'($urandom_range(1));
         ra   = ADDR_W'($urandom);
         dn   = release_at_last && last;
         if (full_q.size() == 0 && $urandom_range(15) == 0) dn = 1'b1;
         tick(v, data_for(cur_tile, wr_cnt), re, ra, dn);
         budget++;
      end
      if (cur_tile == start) check_eq("stream_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [ADDR_W-1:0] addrs[6];
      drive_idle();
      model_reset();
      repeat (3) @(posedge s_clk);
      #1;
      check_outputs();
      @(negedge s_clk);
      s_rst_n = 1'b1;

      // Partial tile, then asynchronous reset mid-tile.
      for (int i = 0; i < 2000; i++) tick(1'b1, data_for(cur_tile, wr_cnt), 1'b0, '0, 1'b0);
      #2;
      s_rst_n = 1'b0;
      drive_idle();
      #1;
      model_reset();
      check_outputs();
      repeat (2) @(posedge s_clk);
      @(negedge s_clk);
      s_rst_n = 1'b1;
      tile_salt[cur_tile] = DATA_W'(20'hA0);

      // Tile 0, contiguous, then targeted reads.
      stream_tile(0, 1'b0);
      tick(1'b0, '0, 1'b1, ADDR_W'(0), 1'b0);
      tick(1'b0, '0, 1'b1, ADDR_W'(1), 1'b0);
      tick(1'b0, '0, 1'b1, ADDR_W'(TILE_BEATS - 1), 1'b0);
      tick(1'b0, '0, 1'b0, '0, 1'b0);

      // Tile 1, gapped; its last beat coincides with the release of tile 0.
      stream_tile(20, 1'b1);
      tick(1'b0, '0, 1'b0, '0, 1'b0);

      // Tile 2 with no release: both banks full, then one overflowing beat.
      stream_tile(10, 1'b0);
      tick(1'b1, ~data_for(cur_tile, wr_cnt), 1'b0, '0, 1'b0);
      addrs[0] = ADDR_W'(0);
      addrs[1] = ADDR_W'(TILE_BEATS - 1);
      for (int i = 2; i < 6; i++) addrs[i] = ADDR_W'($urandom);
      foreach (addrs[i]) tick(1'b0, '0, 1'b1, addrs[i], 1'b0);
      tick(1'b0, '0, 1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1, ADDR_W'($urandom), 1'b0);

      // Ten more tiles each releasing the previous one: heads run through 11 and wrap to 0.
      for (int t = 0; t < 10; t++) stream_tile(5, 1'b1);
      tick(1'b0, '0, 1'b1, ADDR_W'($urandom), 1'b0);
      tick(1'b0, '0, 1'b0, '0, 1'b1);
      tick(1'b0, '0, 1'b1, ADDR_W'($urandom), 1'b1);
      drive_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
